wu_bypass_chain: RTL

Parametrised serial bypass-configuration register for the wake-up/power-management domain. A serial stream is shifted into a staging chain, then length- and parity-checked before being committed atomically to a parallel active register. The active register drives the per-domain power-control bypass overrides. The block also supports capture-and-shift-out readback of the active value, and reports commit status to the controlling shifter.

---
 rtl/wu_bypass_pkg.sv | 23 ++
 rtl/wu_bypass_shifter.sv | 43 ++++
 rtl/wu_bypass_chain.sv | 111 +++++++++++
 3 files changed

// File: rtl/wu_bypass_pkg.sv
// Shared types and helpers for the wake-up bypass configuration chain.
// FSM states, error codes and a width-agnostic parity function.
package wu_bypass_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_PAR  = 2'b10;
    localparam logic [1:0] ERR_BOTH = 2'b11;

    // Zero extension does not alter the XOR, so any width up to 64 fits.
    localparam int PAR_MAX_W = 64;

    function automatic logic par_fn(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/wu_bypass_shifter.sv
// Staging shift chain with a saturating shift counter.
// Saturation at L+1 flags an overlong stream.
module wu_bypass_shifter #(
    parameter int L  = 25,
    parameter int CW = $clog2(L + 2)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          en,
    input  logic          data,
    input  logic          load,
    input  logic [L-1:0]  load_val,
    input  logic          clr,
    output logic [L-1:0]  chain,
    output logic [CW-1:0] count,
    output logic          overlong
);

    localparam logic [CW-1:0] SAT = CW'(L + 1);

    logic [CW-1:0] base;

    // A shift in the evaluation cycle is the first bit of a new stream.
    assign base = clr ? '0 : count;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            chain <= '0;
            count <= '0;
        end else if (en) begin
            chain <= {chain[L-2:0], data};
            count <= (base == SAT) ? SAT : base + 1'b1;
        end else if (load) begin
            chain <= load_val;
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end
    end

    assign overlong = (count == SAT);

endmodule

// File: rtl/wu_bypass_chain.sv
// Serial bypass-configuration register: shift, check, atomic commit.
// Also supports capture of the active value for serial readback.
module wu_bypass_chain
    import wu_bypass_pkg::*;
#(
    parameter int               WIDTH     = 24,
    parameter logic [WIDTH-1:0] RESET_VAL = 24'h0007FF,
    parameter bit               PARITY_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             bypass_data_i,
    input  logic             bypass_en_i,
    input  logic             bypass_capture_i,
    input  logic             bypass_commit_i,
    output logic             bypass_data_o,
    output logic [WIDTH-1:0] bypass_q_o,
    output logic             bypass_valid_o,
    output logic             commit_ack_o,
    output logic             err_o,
    output logic [1:0]       err_code_o
);

    localparam int L  = WIDTH + int'(PARITY_EN);
    localparam int CW = $clog2(L + 2);

    state_e           state;
    logic [L-1:0]     chain;
    logic [L-1:0]     load_val;
    logic [CW-1:0]    count;
    logic             overlong;
    logic [WIDTH-1:0] data_f;
    logic             in_check;
    logic             take_cap;
    logic             par_ok;
    logic             len_ok;

    assign in_check = (state == ST_CHECK);
    assign take_cap = bypass_capture_i && !bypass_en_i && !in_check;
    assign data_f   = chain[L-1 -: WIDTH];
    assign len_ok   = (count == CW'(L)) && !overlong;

    generate
        if (PARITY_EN) begin : g_par
            assign par_ok   = par_fn(PAR_MAX_W'(data_f)) == chain[0];
            assign load_val = {bypass_q_o, par_fn(PAR_MAX_W'(bypass_q_o))};
        end else begin : g_nopar
            assign par_ok   = 1'b1;
            assign load_val = bypass_q_o;
        end
    endgenerate

    wu_bypass_shifter #(
        .L  (L),
        .CW (CW)
    ) u_shifter (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en       (bypass_en_i),
        .data     (bypass_data_i),
        .load     (take_cap),
        .load_val (load_val),
        .clr      (in_check),
        .chain    (chain),
        .count    (count),
        .overlong (overlong)
    );

    assign bypass_data_o = chain[L-1];

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state          <= ST_IDLE;
            bypass_q_o     <= RESET_VAL;
            bypass_valid_o <= 1'b0;
            commit_ack_o   <= 1'b0;
            err_o          <= 1'b0;
            err_code_o     <= ERR_NONE;
        end else begin
            commit_ack_o <= 1'b0;
            unique case (state)
                ST_CHECK: begin
                    if (len_ok && par_ok) begin
                        bypass_q_o     <= data_f;
                        bypass_valid_o <= 1'b1;
                        commit_ack_o   <= 1'b1;
                        err_o          <= 1'b0;
                        err_code_o     <= ERR_NONE;
                    end else begin
                        err_o      <= 1'b1;
                        err_code_o <= !par_ok ?
                                      (!len_ok ? ERR_BOTH : ERR_PAR) :
                                      ERR_LEN;
                    end
                    state <= bypass_en_i ? ST_SHIFT : ST_IDLE;
                end
                default: begin
                    if (bypass_en_i)
                        state <= ST_SHIFT;
                    else if (bypass_capture_i)
                        state <= ST_IDLE;
                    else if (bypass_commit_i)
                        state <= ST_CHECK;
                    else
                        state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
